// File: rtl/foxtrot_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : foxtrot_wb_pkg
// Description : Shared types and widths for the writeback arbiter. The packet
//               widths match the issue-queue result interface.
// Revision    : 1.0 - initial release
// ============================================================================
package foxtrot_wb_pkg;

  localparam int WB_INST_ID_BITS = 6;
  localparam int WB_PRN_BITS     = 6;
  localparam int WB_MAX_OPERANDS = 3;
  localparam int WB_DATA_BITS    = 64;

  // One FU result packet as carried from an issue-queue source to the CDB.
  typedef struct packed {
    logic [WB_INST_ID_BITS-1:0]                   inst_id;
    logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]  prn;
    logic [WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0] data;
    logic [WB_MAX_OPERANDS-1:0]                   data_valid;
  } wb_pkt_t;

  // (base + off) mod n for base < n and off < n; avoids a divider so the
  // round-robin scan also wraps cleanly for non-power-of-two source counts.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Single-source synchronous FIFO of writeback packets. Pointers
//               carry one extra wrap bit so full/empty need no separate
//               counter. A push on a full FIFO is accepted only when the head
//               is popped in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import foxtrot_wb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_pkt_t                  din,
  input  logic                     pop,
  output wb_pkt_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  wb_pkt_t            mem [DEPTH];
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   next_count;
  logic               push_ok;
  logic               pop_ok;
  logic               af_q;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a packet when the slot is freed this cycle.
  assign push_ok = push && (!full || pop_ok);
  assign next_count = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign head        = mem[rd_ptr[ADDR_W-1:0]];
  assign almost_full = af_q;

  // Packet storage; data needs no reset since validity is tracked by pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  // Pointer update and almost-full throttle registered from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      af_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + CNT_W'(1);
      af_q <= (next_count >= CNT_W'(DEPTH - AF_THRESH));
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Buffers FU result packets per source and serialises them onto
//               the common data bus with a round-robin grant that stays locked
//               while the CDB consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import foxtrot_wb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int INST_ID_BITS = WB_INST_ID_BITS,
  parameter int PRN_BITS     = WB_PRN_BITS,
  parameter int MAX_OPERANDS = WB_MAX_OPERANDS,
  parameter int FIFO_DEPTH   = 4,
  parameter int AF_THRESH    = 2,
  localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_SRC-1:0]                                  src_valid,
  input  logic [NUM_SRC-1:0][INST_ID_BITS-1:0]                src_inst_id,
  input  logic [NUM_SRC-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn,
  input  logic [NUM_SRC-1:0][MAX_OPERANDS-1:0][63:0]          src_data,
  input  logic [NUM_SRC-1:0][MAX_OPERANDS-1:0]                src_data_valid,
  output logic [NUM_SRC-1:0]                                  src_almost_full,
  output logic [NUM_SRC-1:0]                                  src_overflow,
  output logic                                                cdb_valid,
  input  logic                                                cdb_ready,
  output logic [INST_ID_BITS-1:0]                             cdb_inst_id,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               cdb_prn,
  output logic [MAX_OPERANDS-1:0][63:0]                       cdb_data,
  output logic [MAX_OPERANDS-1:0]                             cdb_data_valid,
  output logic [SRC_W-1:0]                                    cdb_src
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_pkt_t              push_pkt [NUM_SRC];
  wb_pkt_t              head_pkt [NUM_SRC];
  wb_pkt_t              cdb_pkt;
  logic [NUM_SRC-1:0]   fifo_full;
  logic [NUM_SRC-1:0]   fifo_empty;
  logic [NUM_SRC-1:0]   fifo_pop;
  logic [NUM_SRC-1:0]   fifo_af;
  logic [CNT_W-1:0]     fifo_count_unused [NUM_SRC];

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     scan_grant;
  logic [SRC_W-1:0]     grant;
  logic [SRC_W-1:0]     hold_grant;
  logic                 hold_valid;
  logic                 transfer;
  logic [NUM_SRC-1:0]   overflow_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push_pkt[i] = '{inst_id:    src_inst_id[i],
                           prn:        src_prn[i],
                           data:       src_data[i],
                           data_valid: src_data_valid[i]};
    assign fifo_pop[i] = transfer && (grant == SRC_W'(i));

    wb_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (src_valid[i]),
      .din         (push_pkt[i]),
      .pop         (fifo_pop[i]),
      .head        (head_pkt[i]),
      .full        (fifo_full[i]),
      .empty       (fifo_empty[i]),
      .count       (fifo_count_unused[i]),
      .almost_full (fifo_af[i])
    );
  end

  // Round-robin scan: first non-empty FIFO starting at rr_ptr.
  always_comb begin
    int idx;
    logic found;
    scan_grant = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = wrap_idx(int'(rr_ptr), k, NUM_SRC);
      if (!found && !fifo_empty[idx]) begin
        found      = 1'b1;
        scan_grant = SRC_W'(idx);
      end
    end
  end

  // A stalled grant stays locked so the CDB payload cannot change under the consumer.
  assign grant     = hold_valid ? hold_grant : scan_grant;
  assign cdb_valid = ~&fifo_empty;
  assign transfer  = cdb_valid && cdb_ready;
  assign cdb_pkt   = head_pkt[grant];

  assign cdb_inst_id     = cdb_pkt.inst_id;
  assign cdb_prn         = cdb_pkt.prn;
  assign cdb_data        = cdb_pkt.data;
  assign cdb_data_valid  = cdb_pkt.data_valid;
  assign cdb_src         = grant;
  assign src_almost_full = fifo_af;
  assign src_overflow    = overflow_q;

  // Round-robin pointer advances past the winner on each completed transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
    end
  end

  // Remember the grant across a stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_grant <= '0;
    end else begin
      hold_valid <= cdb_valid && !cdb_ready;
      hold_grant <= grant;
    end
  end

  // Sticky drop flag: a push that found its FIFO full with no pop this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= overflow_q | (src_valid & fifo_full & ~fifo_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: directed scenarios plus
//               randomized traffic against a queue-based reference model, and
//               a three-source instance for round-robin wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import foxtrot_wb_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int AFT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Four-source DUT
  logic                    rst;
  logic [N-1:0]            src_valid;
  wb_pkt_t                 drv_pkt [N];
  logic [N-1:0][5:0]       src_inst_id;
  logic [N-1:0][2:0][5:0]  src_prn;
  logic [N-1:0][2:0][63:0] src_data;
  logic [N-1:0][2:0]       src_data_valid;
  logic [N-1:0]            src_almost_full;
  logic [N-1:0]            src_overflow;
  logic                    cdb_valid;
  logic                    cdb_ready;
  logic [5:0]              cdb_inst_id;
  logic [2:0][5:0]         cdb_prn;
  logic [2:0][63:0]        cdb_data;
  logic [2:0]              cdb_data_valid;
  logic [1:0]              cdb_src;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign src_inst_id[g]    = drv_pkt[g].inst_id;
    assign src_prn[g]        = drv_pkt[g].prn;
    assign src_data[g]       = drv_pkt[g].data;
    assign src_data_valid[g] = drv_pkt[g].data_valid;
  end

  wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_inst_id(src_inst_id),
    .src_prn(src_prn), .src_data(src_data), .src_data_valid(src_data_valid),
    .src_almost_full(src_almost_full), .src_overflow(src_overflow),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_inst_id(cdb_inst_id),
    .cdb_prn(cdb_prn), .cdb_data(cdb_data), .cdb_data_valid(cdb_data_valid),
    .cdb_src(cdb_src)
  );

  // Three-source DUT for non-power-of-two wrap
  logic                    rst3;
  logic [2:0]              v3;
  logic [2:0][5:0]         inst3;
  logic [2:0][2:0][5:0]    prn3;
  logic [2:0][2:0][63:0]   data3;
  logic [2:0][2:0]         dv3;
  logic [2:0]              af3;
  logic [2:0]              ovf3;
  logic                    cv3;
  logic                    cr3;
  logic [5:0]              cinst3;
  logic [2:0][5:0]         cprn3;
  logic [2:0][63:0]        cdata3;
  logic [2:0]              cdv3;
  logic [1:0]              csrc3;

  wb_arbiter #(.NUM_SRC(3), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT)) dut3 (
    .clk(clk), .rst(rst3), .src_valid(v3), .src_inst_id(inst3),
    .src_prn(prn3), .src_data(data3), .src_data_valid(dv3),
    .src_almost_full(af3), .src_overflow(ovf3),
    .cdb_valid(cv3), .cdb_ready(cr3), .cdb_inst_id(cinst3),
    .cdb_prn(cprn3), .cdb_data(cdata3), .cdb_data_valid(cdv3),
    .cdb_src(csrc3)
  );

  // Reference model: per-source packet queues, round-robin pointer, and the
  // grant that was left waiting by a stalled consumer.
  wb_pkt_t   mq [N][$];
  int        rr;
  logic [N-1:0] movf;
  bit        stalled;
  int        stall_g;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_any();
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_grant();
    if (stalled) return stall_g;
    for (int k = 0; k < N; k++) begin
      if (mq[(rr + k) % N].size() != 0) return (rr + k) % N;
    end
    return 0;
  endfunction

  function automatic wb_pkt_t mkpkt(input int id);
    wb_pkt_t p;
    p.inst_id = 6'(id);
    for (int j = 0; j < 3; j++) begin
      p.prn[j]  = 6'($urandom);
      p.data[j] = {$urandom, $urandom};
    end
    p.data_valid = 3'($urandom);
    return p;
  endfunction

  // Compare DUT outputs against the model midway through the cycle.
  task automatic sample();
    bit v;
    int g;
    wb_pkt_t obs;
    logic [N-1:0] af_exp;
    @(negedge clk);
    v = model_any();
    g = model_grant();
    check("cdb_valid", 256'(cdb_valid), 256'(v));
    if (v) begin
      obs.inst_id    = cdb_inst_id;
      obs.prn        = cdb_prn;
      obs.data       = cdb_data;
      obs.data_valid = cdb_data_valid;
      check("cdb_src", 256'(cdb_src), 256'(g));
      check("cdb_pkt", 256'(obs), 256'(mq[g][0]));
    end
    for (int i = 0; i < N; i++) af_exp[i] = (mq[i].size() >= DEPTH - AFT);
    check("almost_full", 256'(src_almost_full), 256'(af_exp));
    check("overflow", 256'(src_overflow), 256'(movf));
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic step();
    bit v;
    int g;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr      = 0;
      movf    = '0;
      stalled = 1'b0;
    end else begin
      v = model_any();
      g = model_grant();
      if (v && cdb_ready) begin
        void'(mq[g].pop_front());
        rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(drv_pkt[i]);
          else movf[i] = 1'b1;
        end
      end
      stalled = v && !cdb_ready;
      stall_g = g;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; cdb_ready = 1'b0;
    for (int i = 0; i < N; i++) drv_pkt[i] = '0;
    rst3 = 1'b1; v3 = '0; cr3 = 1'b0; inst3 = '0; prn3 = '0; data3 = '0; dv3 = '0;
    rr = 0; movf = '0; stalled = 1'b0; stall_g = 0;

    step();
    rst = 1'b0;
    sample(); step();

    // Single packet from source 2
    src_valid = 4'b0100;
    drv_pkt[2] = '0;
    drv_pkt[2].inst_id = 6'd5;
    drv_pkt[2].prn[0] = 6'd7;
    drv_pkt[2].data[0] = 64'hDEAD;
    drv_pkt[2].data_valid = 3'b001;
    cdb_ready = 1'b1;
    sample(); step();
    src_valid = '0;
    sample();
    check("single_valid", 256'(cdb_valid), 256'(1));
    check("single_src", 256'(cdb_src), 256'(2));
    check("single_id", 256'(cdb_inst_id), 256'(5));
    check("single_data0", 256'(cdb_data[0]), 256'(64'hDEAD));
    step();
    sample();
    check("single_gone", 256'(cdb_valid), 256'(0));
    step();

    // Fairness: two simultaneous bursts from all sources
    rst = 1'b1; sample(); step(); rst = 1'b0;
    for (int b = 0; b < 2; b++) begin
      src_valid = '1;
      for (int i = 0; i < N; i++) drv_pkt[i] = mkpkt(10 + i);
      sample(); step();
      src_valid = '0;
      for (int k = 0; k < N; k++) begin
        sample();
        check("fair_order", 256'(cdb_inst_id), 256'(10 + k));
        step();
      end
    end

    // Backpressure on source 0 with a fifth push dropped
    cdb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_valid = 4'b0001;
      drv_pkt[0] = mkpkt(20 + k);
      sample();
      if (k > 0) check("bp_hold", 256'(cdb_inst_id), 256'(20));
      step();
    end
    src_valid = '0;
    sample();
    check("bp_af", 256'(src_almost_full[0]), 256'(1));
    check("bp_ovf", 256'(src_overflow[0]), 256'(1));
    step();
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("bp_drain", 256'(cdb_inst_id), 256'(20 + k));
      step();
    end
    sample();
    check("bp_empty", 256'(cdb_valid), 256'(0));
    step();

    // Push into full FIFO 1 while it is being popped
    cdb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_valid = 4'b0010;
      drv_pkt[1] = mkpkt(30 + k);
      sample(); step();
    end
    cdb_ready = 1'b1;
    src_valid = 4'b0010;
    drv_pkt[1] = mkpkt(34);
    sample();
    check("pof_src", 256'(cdb_src), 256'(1));
    step();
    src_valid = '0; cdb_ready = 1'b0;
    sample();
    check("pof_ovf", 256'(src_overflow[1]), 256'(0));
    check("pof_af", 256'(src_almost_full[1]), 256'(1));
    step();
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("pof_drain", 256'(cdb_inst_id), 256'(31 + k));
      step();
    end

    // Reset with packets buffered and overflow still sticky from earlier
    cdb_ready = 1'b0;
    src_valid = 4'b0111;
    for (int i = 0; i < 3; i++) drv_pkt[i] = mkpkt(40 + i);
    sample(); step();
    src_valid = '0; rst = 1'b1;
    sample(); step();
    rst = 1'b0;
    sample();
    check("rst_valid", 256'(cdb_valid), 256'(0));
    check("rst_ovf", 256'(src_overflow), 256'(0));
    check("rst_af", 256'(src_almost_full), 256'(0));
    src_valid = 4'b1000;
    drv_pkt[3] = mkpkt(43);
    step();
    src_valid = '0;
    sample();
    check("rst_new_src", 256'(cdb_src), 256'(3));
    step();

    // Randomized traffic in alternating light/heavy backpressure phases
    for (int n = 0; n < 800; n++) begin
      int ready_pct;
      ready_pct = ((n / 100) % 2 == 1) ? 30 : 85;
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        src_valid[i] = ($urandom_range(0, 99) < 35);
        drv_pkt[i]   = mkpkt(int'($urandom_range(0, 63)));
      end
      cdb_ready = ($urandom_range(0, 99) < ready_pct);
      sample(); step();
    end
    rst = 1'b0; src_valid = '0;

    // Three sources, 0 and 2 always pushing: grants must alternate 0,2,0,2
    rst3 = 1'b0; v3 = 3'b101; cr3 = 1'b1;
    inst3[0] = 6'd50; inst3[2] = 6'd52;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr3_valid", 256'(cv3), 256'(1));
      check("rr3_src", 256'(csrc3), 256'((k % 2 == 1) ? 2 : 0));
      check("rr3_id", 256'(cinst3), 256'((k % 2 == 1) ? 52 : 50));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter directly downstream of the issue queues. Collects the fu_out_* result packets produced by NUM_SRC issue-queue/FU pairs and buffers each source in a small FIFO. A round-robin arbiter serialises the buffered packets onto a single common data bus (CDB) that feeds the ROB, register file and operand wakeup logic. FU outputs have no backpressure, so each FIFO raises an almost-full throttle back to its issue queue.

Parameters:
NUM_SRC, 4, number of issue-queue/FU result sources
INST_ID_BITS, 6, instruction ID width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, result slots per packet
FIFO_DEPTH, 4, entries per source FIFO (power of two, >=2)
AF_THRESH, 2, almost-full asserts when occupancy >= FIFO_DEPTH-AF_THRESH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_valid  in  [NUM_SRC]  fu_out_valid per source
src_inst_id  in  [NUM_SRC][INST_ID_BITS]  fu_out_inst_id per source
src_prn  in  [NUM_SRC][MAX_OPERANDS][PRN_BITS]  fu_out_prn per source
src_data  in  [NUM_SRC][MAX_OPERANDS][64]  fu_out_data per source
src_data_valid  in  [NUM_SRC][MAX_OPERANDS]  fu_out_data_valid per source
src_almost_full  out  [NUM_SRC]  throttle to issue queue (suppress issue)
src_overflow  out  [NUM_SRC]  sticky: packet dropped on full FIFO
cdb_valid  out  1  CDB packet valid
cdb_ready  in  1  consumer accepts CDB packet
cdb_inst_id  out  INST_ID_BITS  granted packet instruction ID
cdb_prn  out  [MAX_OPERANDS][PRN_BITS]  granted packet PRNs
cdb_data  out  [MAX_OPERANDS][64]  granted packet data
cdb_data_valid  out  [MAX_OPERANDS]  granted packet slot valids
cdb_src  out  $clog2(NUM_SRC)  index of granted source (debug/perf)

Behaviour:
- Reset (rst=1 at posedge): all FIFOs empty, rr_ptr=0, src_overflow=0, src_almost_full=0, cdb_valid=0. Reset mid-operation discards all buffered packets; no CDB transfer completes in the reset cycle.
- Push: src_valid[i]=1 at posedge writes the packet into FIFO i. All sources may push in the same cycle.
- Full handling: a push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and FIFO i is popped that same cycle. Otherwise the packet is dropped, count unchanged, src_overflow[i] set (sticky until rst).
- CDB output is combinational from the FIFO heads and the grant. Minimum latency: src_valid at edge N -> cdb_valid in cycle N+1. No same-cycle bypass.
- Arbitration: grant = first non-empty FIFO scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC. cdb_valid = any FIFO non-empty. cdb_* fields come from the granted head.
- Transfer occurs when cdb_valid && cdb_ready. On transfer, pop the granted FIFO and set rr_ptr <= (grant+1) mod NUM_SRC. Without a transfer, rr_ptr holds.
- Stability: while cdb_valid && !cdb_ready, the grant and cdb_* hold steady even if other FIFOs fill. Grant is recomputed only after a transfer or when the previously valid output was absent.
- Order: per-source FIFO order is preserved. No ordering is guaranteed across sources.
- src_almost_full[i] is registered from next-state occupancy: asserted the cycle after occupancy reaches FIFO_DEPTH-AF_THRESH.
- Pointer wrap: read/write pointers carry one extra bit, giving full/empty without a separate counter. rr_ptr wraps at NUM_SRC, including non-power-of-two values.
- Packet fields pass through unmodified. A packet with all src_data_valid=0 is still buffered and broadcast (completion-only instruction).

Decomposition:
- Package foxtrot_wb_pkg: typedef wb_pkt_t (inst_id, prn[MAX_OPERANDS], data[MAX_OPERANDS], data_valid[MAX_OPERANDS]); width constants shared with the issue-queue interface parameters.
- Sub-module wb_fifo: single-source synchronous FIFO of wb_pkt_t. Ports: push, pop, full, empty, count, head, plus almost_full. Instantiated NUM_SRC times.
- Round-robin picker stays in wb_arbiter.

Test Plan:
- Single packet: src_valid[2]=1, inst_id=5, prn={7,0,0}, data[0]=0xDEAD, data_valid={1,0,0}, cdb_ready=1 -> next cycle cdb_valid=1, cdb_src=2, cdb_inst_id=5, cdb_data[0]=0xDEAD. The cycle after that, cdb_valid=0.
- Fairness: all 4 sources push one packet in the same cycle (ids 10..13), cdb_ready=1 -> CDB ids 10,11,12,13 on consecutive cycles. Then rr_ptr=0; a second simultaneous burst again yields 10..13 order.
- Backpressure: cdb_ready=0, source 0 pushes 4 packets -> cdb holds the first packet steady. src_almost_full[0]=1 after the 2nd push. A 5th push sets src_overflow[0]=1 and is dropped. Releasing cdb_ready drains exactly 4 packets in order.
- Push on full with pop: FIFO 1 full, cdb granted to source 1, cdb_ready=1, src_valid[1]=1 same cycle -> no overflow, occupancy stays 4.
- Reset mid-operation: 3 packets buffered, assert rst one cycle -> next cycle cdb_valid=0, src_overflow=0, src_almost_full=0. A new push appears 1 cycle later with cdb_src matching its source.
- NUM_SRC=3: sources 0 and 2 continuously full, source 1 idle -> grants alternate 0,2,0,2, confirming wrap of rr_ptr from 2 to 0.
